ram_wr_arbiter: RTL and testbench

RAM_WR_ARBITER -- requirements
Module: ram_wr_arbiter

---
 rtl/definitions.sv | 20 ++
 rtl/fill_addr_gen.sv | 39 +++
 rtl/ram_wr_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_wr_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared types and helpers for the RAM write-port arbiter.
package ram_wr_arbiter_pkg;

    // Fill engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    // Width of a counter that must hold values 0..limit (at least 1 bit).
    function automatic int cnt_width(input int limit);
        if (limit > 0) begin
            return $clog2(limit + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Fill address / remaining-count generator. The address wraps naturally
// at 2**ADDR_WIDTH; the remaining count steps down once per fill write.
module fill_addr_gen #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] remaining_r;

    // Load on a new fill, advance on each granted fill write.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r      <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {ADDR_WIDTH{1'b0}};
        end else if (load) begin
            addr_r      <= base;
            remaining_r <= len;
        end else if (step) begin
            addr_r      <= addr_r + ADDR_WIDTH'(1);
            remaining_r <= remaining_r - ADDR_WIDTH'(1);
        end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
        end
    end

    assign addr = addr_r;
    assign last = (remaining_r == ADDR_WIDTH'(1));

endmodule

// File: rtl/ram_wr_arbiter.sv
// Shared RAM write-port arbiter: the CPU has zero-latency priority, a fill
// engine uses idle cycles, and a starvation counter forces one fill write
// after STARVE_LIMIT consecutive CPU-owned fill cycles.
module ram_wr_arbiter
    import ram_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 15,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_write_m,
    input  logic [ADDR_WIDTH-1:0] cpu_write_addr,
    input  logic [DATA_WIDTH-1:0] cpu_out_m,
    output logic                  cpu_stall,
    input  logic                  fill_start,
    input  logic                  fill_abort,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH-1:0] fill_len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic                  write_m,
    output logic [ADDR_WIDTH-1:0] write_data_addr,
    output logic [DATA_WIDTH-1:0] out_m
);

    localparam int              CNT_W   = cnt_width(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    fill_state_e           state_r;
    fill_state_e           state_next_s;
    logic [DATA_WIDTH-1:0] value_r;
    logic [CNT_W-1:0]      starve_r;
    logic [ADDR_WIDTH-1:0] fill_addr_s;
    logic                  fill_last_s;
    logic                  load_s;
    logic                  in_fill_s;
    logic                  forced_s;
    logic                  fill_grant_s;
    logic                  stall_s;

    assign in_fill_s = (state_r == ST_FILL);
    assign load_s    = (state_r == ST_IDLE) && fill_start && (fill_len != {ADDR_WIDTH{1'b0}});
    assign forced_s  = in_fill_s && (STARVE_LIMIT != 0) && (starve_r == LIMIT_C);
    // An abort suppresses the fill write; the CPU is then not held back.
    assign fill_grant_s = in_fill_s && !fill_abort && (!cpu_write_m || forced_s);
    assign stall_s      = forced_s && cpu_write_m && !fill_abort;

    fill_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .step (fill_grant_s),
        .base (fill_base),
        .len  (fill_len),
        .addr (fill_addr_s),
        .last (fill_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and write-port mux.
    always_comb begin
        state_next_s    = state_r;
        cpu_stall       = 1'b0;
        write_m         = cpu_write_m;
        write_data_addr = cpu_write_addr;
        out_m           = cpu_out_m;
        case (state_r)
            ST_IDLE: begin
                if (fill_start) begin
                    if (fill_len != {ADDR_WIDTH{1'b0}}) begin
                        state_next_s = ST_FILL;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                cpu_stall = stall_s;
                if (fill_grant_s) begin
                    write_m         = 1'b1;
                    write_data_addr = fill_addr_s;
                    out_m           = value_r;
                end else begin
                    write_m = cpu_write_m;
                end
                if (fill_abort) begin
                    state_next_s = ST_IDLE;
                end else if (fill_grant_s && fill_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Latch the fill value when a non-empty fill is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= {DATA_WIDTH{1'b0}};
        end else if (load_s) begin
            value_r <= fill_value;
        end else begin
            value_r <= value_r;
        end
    end

    // Starvation counter: counts CPU-owned FILL cycles, cleared by any fill
    // grant, an abort, or leaving FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= {CNT_W{1'b0}};
        end else if (!in_fill_s || fill_abort || fill_grant_s) begin
            starve_r <= {CNT_W{1'b0}};
        end else if (cpu_write_m && (starve_r != {CNT_W{1'b1}})) begin
            starve_r <= starve_r + CNT_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    assign fill_busy = in_fill_s;
    assign fill_done = (state_r == ST_DONE);

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Scoreboard bench for ram_wr_arbiter: a behavioural model predicts each
// cycle's port outputs, a monitor compares them on the falling edge.
module tb_ram_wr_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 15;
    localparam int LIMIT = 8;

    typedef struct {
        bit          wm;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit          stall;
        bit          busy;
        bit          done;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_write_m = 1'b0;
    logic [AW-1:0] cpu_write_addr = '0;
    logic [DW-1:0] cpu_out_m = '0;
    logic          cpu_stall;
    logic          fill_start = 1'b0;
    logic          fill_abort = 1'b0;
    logic [AW-1:0] fill_base = '0;
    logic [AW-1:0] fill_len = '0;
    logic [DW-1:0] fill_value = '0;
    logic          fill_busy;
    logic          fill_done;
    logic          write_m;
    logic [AW-1:0] write_data_addr;
    logic [DW-1:0] out_m;

    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;
    bit   stim_done = 1'b0;
    exp_t exp_q[$];

    // Reference model state (starts in the reset state).
    bit m_busy = 1'b0, m_done = 1'b0;
    int m_addr = 0, m_left = 0, m_val = 0, m_starve = 0;

    ram_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_write_m(cpu_write_m), .cpu_write_addr(cpu_write_addr), .cpu_out_m(cpu_out_m),
        .cpu_stall(cpu_stall),
        .fill_start(fill_start), .fill_abort(fill_abort),
        .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .write_m(write_m), .write_data_addr(write_data_addr), .out_m(out_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs, predict outputs, advance the model.
    task automatic cycle(input bit r, input bit we, input int a, input int d,
                         input bit st, input bit ab, input int b, input int l,
                         input int v, output bit stalled);
        exp_t e;
        bit forced, fw;
        @(posedge clk);
        #1;
        rst = r; cpu_write_m = we; cpu_write_addr = AW'(a); cpu_out_m = DW'(d);
        fill_start = st; fill_abort = ab; fill_base = AW'(b); fill_len = AW'(l);
        fill_value = DW'(v);
        forced  = m_busy && (LIMIT != 0) && (m_starve == LIMIT);
        fw      = m_busy && !ab && (!we || forced);
        e.stall = forced && we && !ab;
        e.wm    = fw || (we && !e.stall);
        e.a     = fw ? AW'(m_addr) : AW'(a);
        e.d     = fw ? DW'(m_val) : DW'(d);
        e.busy  = m_busy;
        e.done  = m_done;
        exp_q.push_back(e);
        started = 1'b1;
        stalled = e.stall;
        if (r) begin
            m_busy = 0; m_done = 0; m_addr = 0; m_left = 0; m_val = 0; m_starve = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (ab) begin
                m_busy = 0; m_starve = 0;
            end else if (fw) begin
                m_addr   = (m_addr + 1) % (1 << AW);
                m_left   = m_left - 1;
                m_starve = 0;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end else begin
                m_starve = m_starve + 1;
            end
        end else if (st) begin
            if ((l % (1 << AW)) == 0) begin
                m_done = 1;
            end else begin
                m_busy = 1; m_addr = b % (1 << AW); m_left = l % (1 << AW);
                m_val = v % (1 << DW);
            end
        end
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
    endtask

    task automatic start_fill(input int b, input int l, input int v);
        bit s;
        cycle(0, 0, 0, 0, 1, 0, b, l, v, s);
    endtask

    // Monitor: compare every presented cycle against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("write_m", {31'd0, write_m}, {31'd0, e.wm});
            chk("write_data_addr", {17'd0, write_data_addr}, {17'd0, e.a});
            chk("out_m", {16'd0, out_m}, {16'd0, e.d});
            chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
            chk("fill_busy", {31'd0, fill_busy}, {31'd0, e.busy});
            chk("fill_done", {31'd0, fill_done}, {31'd0, e.done});
        end else if (started && !stim_done) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no prediction queued at %0t", $time);
        end
    end

    initial begin
        bit s;
        int k;
        // Reset and CPU pass-through.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, s);
        cycle(1, 1, 'h55, 'h1234, 0, 0, 0, 0, 0, s);
        cycle(0, 1, 'h123, 'hBEEF, 0, 0, 0, 0, 0, s);
        idle(1);

        // Basic fill with idle CPU.
        start_fill('h10, 4, 'hAAAA);
        idle(7);

        // Address wrap.
        start_fill('h7FFE, 3, 'h5A5A);
        idle(6);

        // Continuous CPU writes force one fill write after LIMIT cycles.
        start_fill('h100, 3, 'h0F0F);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 'h200 + k, 'hC000 + k, 0, 0, 0, 0, 0, s);
            if (!s) k++;
        end
        idle(6);

        // Abort on the final write.
        start_fill('h40, 2, 'h1111);
        idle(1);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0, s);
        idle(3);

        // Zero-length fill; starts during DONE and FILL are ignored.
        start_fill('h300, 0, 'h2222);
        cycle(0, 0, 0, 0, 1, 0, 'h310, 3, 'h3333, s);
        idle(2);
        start_fill('h400, 4, 'h4444);
        cycle(0, 0, 0, 0, 1, 0, 'h500, 2, 'h5555, s);
        idle(6);

        // Abort outside FILL is ignored.
        cycle(0, 1, 'h77, 'h7777, 0, 1, 0, 0, 0, s);

        // Reset mid-fill, then CPU write passes through.
        start_fill('h600, 5, 'h6666);
        idle(2);
        cycle(1, 1, 'h610, 'h6161, 0, 0, 0, 0, 0, s);
        cycle(0, 1, 'h611, 'h6262, 0, 0, 0, 0, 0, s);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, we, st, ab;
            int b;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 99) < 70);
            st = ($urandom_range(0, 9) == 0);
            ab = ($urandom_range(0, 39) == 0);
            b  = ($urandom_range(0, 3) == 0) ? (32768 - $urandom_range(1, 6)) : $urandom_range(0, 32767);
            cycle(r, we, $urandom_range(0, 32767), $urandom_range(0, 65535), st, ab,
                  b, $urandom_range(0, 12), $urandom_range(0, 65535), s);
        end
        idle(20);

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
